fu_result_queue: RTL and testbench

- Parametrised successor to the single-stage functional unit output buffer: a DEPTH-entry circular FIFO of (value, tag, exception) results from one functional unit.
- Sits between a functional unit and the common data bus (CDB).
- Raises a request to the CDB arbiter whenever non-empty and drives the shared CDB only while granted.
- Adds backpressure (full, count), an overflow error flag, and pipeline flush.

---
 rtl/ooo_pkg.sv | 14 +
 rtl/fu_result_queue_if.sv | 40 ++++
 rtl/fu_result_queue.sv | 102 ++++++++++
 tb/tb_fu_result_queue.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: the result record carried on the common
// data bus, also stored by reservation stations and the reorder buffer.
package ooo_pkg;

    localparam int XLEN_DEFAULT      = 32;
    localparam int TAG_WIDTH_DEFAULT = 6;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0]      value;
        logic [TAG_WIDTH_DEFAULT-1:0] tag;
        logic                         exception;
    } cdb_entry_t;

endpackage

// File: rtl/fu_result_queue_if.sv
// Functional-unit side and CDB-arbiter side of the result queue.
// Handshake: write_en is a push request, accepted on the rising edge when
// !full or when a pop happens in the same cycle; cdb_permit is the arbiter
// grant, and a pop (cdb_valid) occurs in any cycle where cdb_permit is high
// and not_empty is high. not_empty is the request to the arbiter.
interface fu_result_queue_if #(
    parameter int XLEN      = 32,
    parameter int TAG_WIDTH = 6,
    parameter int DEPTH     = 4
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0]      value;
    logic [TAG_WIDTH-1:0] tag;
    logic                 exception;
    logic                 write_en;
    logic                 flush;
    logic                 full;
    logic                 not_empty;
    logic [CW-1:0]        count;
    logic                 overflow;
    logic                 cdb_permit;
    logic                 cdb_valid;
    logic [PW-1:0]        read_from;
    logic [PW-1:0]        write_to;

    // Producer side: functional unit, flush control and CDB arbiter.
    modport master (
        output value, tag, exception, write_en, flush, cdb_permit,
        input  full, not_empty, count, overflow, cdb_valid, read_from, write_to
    );

    // The queue itself.
    modport slave (
        input  value, tag, exception, write_en, flush, cdb_permit,
        output full, not_empty, count, overflow, cdb_valid, read_from, write_to
    );

endinterface

// File: rtl/fu_result_queue.sv
// DEPTH-entry circular FIFO of functional-unit results feeding the shared
// CDB. The CDB data wires are tristate ports because several units drive
// the same bus; only the granted unit leaves them out of high-Z.
module fu_result_queue
    import ooo_pkg::*;
#(
    parameter int XLEN      = XLEN_DEFAULT,
    parameter int TAG_WIDTH = TAG_WIDTH_DEFAULT,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    fu_result_queue_if.slave     q,
    output logic [XLEN-1:0]      cdb_data,
    output logic [TAG_WIDTH-1:0] cdb_tag,
    output logic                 cdb_exception
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] read_from_q, read_from_d;
    logic [PW-1:0] write_to_q, write_to_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    cdb_entry_t    mem_q [DEPTH];
    cdb_entry_t    head;
    cdb_entry_t    wr_entry;

    logic          full;
    logic          not_empty;
    logic          pop;
    logic          push;

    assign not_empty = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = q.cdb_permit && not_empty;
    // A full queue still accepts a write when the head leaves the same cycle;
    // a flush discards any write presented with it.
    assign push      = q.write_en && (!full || pop) && !q.flush;

    assign head = mem_q[read_from_q];

    // Pack the incoming result into the shared CDB record layout.
    always_comb begin
        wr_entry           = '0;
        wr_entry.value     = XLEN_DEFAULT'(q.value);
        wr_entry.tag       = TAG_WIDTH_DEFAULT'(q.tag);
        wr_entry.exception = q.exception;
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        read_from_d = read_from_q;
        write_to_d  = write_to_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (q.write_en && full && !pop);
        if (q.flush) begin
            read_from_d = '0;
            write_to_d  = '0;
            count_d     = '0;
        end else begin
            if (pop)  read_from_d = read_from_q + PW'(1);
            if (push) write_to_d  = write_to_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state register; reset dominates flush, push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_from_q <= '0;
            write_to_q  <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            read_from_q <= read_from_d;
            write_to_q  <= write_to_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // Entry storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push && !reset) mem_q[write_to_q] <= wr_entry;
    end

    assign q.full      = full;
    assign q.not_empty = not_empty;
    assign q.count     = count_q;
    assign q.overflow  = overflow_q;
    assign q.cdb_valid = pop;
    assign q.read_from = read_from_q;
    assign q.write_to  = write_to_q;

    // Drive the shared bus only in the granted cycle, straight from the head.
    assign cdb_data      = pop ? XLEN'(head.value)     : 'z;
    assign cdb_tag       = pop ? TAG_WIDTH'(head.tag)  : 'z;
    assign cdb_exception = pop ? head.exception        : 1'bz;

endmodule

// File: tb/tb_fu_result_queue.sv
// Directed bench for fu_result_queue with DEPTH=4: reset/idle, fill, overflow,
// push-while-popping at full, in-order drain, exception bit, and flush.
module tb_fu_result_queue;

    localparam int XLEN      = 32;
    localparam int TAG_WIDTH = 6;
    localparam int DEPTH     = 4;

    logic clk;
    logic reset;
    wire [XLEN-1:0]      cdb_data;
    wire [TAG_WIDTH-1:0] cdb_tag;
    wire                 cdb_exception;

    int compared;
    int mismatched;

    fu_result_queue_if #(.XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH), .DEPTH(DEPTH)) bus ();

    fu_result_queue #(.XLEN(XLEN), .TAG_WIDTH(TAG_WIDTH), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .q             (bus.slave),
        .cdb_data      (cdb_data),
        .cdb_tag       (cdb_tag),
        .cdb_exception (cdb_exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [XLEN-1:0] v, input logic [TAG_WIDTH-1:0] t,
                         input logic e, input logic permit, input logic fl);
        bus.write_en   = we;
        bus.value      = v;
        bus.tag        = t;
        bus.exception  = e;
        bus.cdb_permit = permit;
        bus.flush      = fl;
        #1;
    endtask

    logic [XLEN-1:0]      drain_val [4];
    logic [TAG_WIDTH-1:0] drain_tag [4];

    initial begin
        compared   = 0;
        mismatched = 0;
        drain_val  = '{32'h11, 32'h12, 32'h13, 32'h20};
        drain_tag  = '{6'd2, 6'd3, 6'd4, 6'd5};

        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;

        // Reset then idle with garbage on value/tag.
        drive(1'b0, 32'h1, 6'd2, 1'b0, 1'b0, 1'b0);
        tick();
        chk("idle_count",     64'(bus.count), 0);
        chk("idle_not_empty", 64'(bus.not_empty), 0);
        chk("idle_full",      64'(bus.full), 0);
        chk("idle_cdb_valid", 64'(bus.cdb_valid), 0);
        chk("idle_overflow",  64'(bus.overflow), 0);
        chk("idle_read_from", 64'(bus.read_from), 0);
        chk("idle_write_to",  64'(bus.write_to), 0);

        // Fill to full without grant.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h10 + 32'(i), 6'(i + 1), 1'b0, 1'b0, 1'b0);
            tick();
            chk($sformatf("fill_count_%0d", i), 64'(bus.count), 64'(i + 1));
            chk($sformatf("fill_full_%0d", i), 64'(bus.full), (i == 3) ? 64'd1 : 64'd0);
        end
        chk("fill_write_to_wrap", 64'(bus.write_to), 0);
        chk("fill_not_empty",     64'(bus.not_empty), 1);

        // Push while full and not granted: dropped, overflow set.
        drive(1'b1, 32'h99, 6'd9, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ovf_flag",     64'(bus.overflow), 1);
        chk("ovf_count",    64'(bus.count), 4);
        chk("ovf_write_to", 64'(bus.write_to), 0);

        // Push and pop together at full: slot reused.
        drive(1'b1, 32'h20, 6'd5, 1'b0, 1'b1, 1'b0);
        chk("pp_cdb_valid", 64'(bus.cdb_valid), 1);
        chk("pp_cdb_data",  64'(cdb_data), 64'h10);
        chk("pp_cdb_tag",   64'(cdb_tag), 1);
        tick();
        chk("pp_count",     64'(bus.count), 4);
        chk("pp_full",      64'(bus.full), 1);
        chk("pp_read_from", 64'(bus.read_from), 1);
        chk("pp_write_to",  64'(bus.write_to), 1);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("drain_valid_%0d", i), 64'(bus.cdb_valid), 1);
            chk($sformatf("drain_data_%0d", i),  64'(cdb_data), 64'(drain_val[i]));
            chk($sformatf("drain_tag_%0d", i),   64'(cdb_tag), 64'(drain_tag[i]));
            tick();
        end
        chk("drained_count",     64'(bus.count), 0);
        chk("drained_cdb_valid", 64'(bus.cdb_valid), 0);
        chk("drained_not_empty", 64'(bus.not_empty), 0);
        chk("drained_overflow",  64'(bus.overflow), 1);
        chk("drained_read_from", 64'(bus.read_from), 1);

        // Grant while empty: nothing moves.
        tick();
        chk("empty_grant_read_from", 64'(bus.read_from), 1);
        chk("empty_grant_count",     64'(bus.count), 0);

        // Exception entry; no same-cycle bypass into an empty queue.
        drive(1'b1, 32'hDEAD, 6'd7, 1'b1, 1'b1, 1'b0);
        chk("exc_no_bypass", 64'(bus.cdb_valid), 0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("exc_cdb_valid", 64'(bus.cdb_valid), 1);
        chk("exc_cdb_exc",   64'(cdb_exception), 1);
        chk("exc_cdb_tag",   64'(cdb_tag), 7);
        chk("exc_cdb_data",  64'(cdb_data), 64'hDEAD);
        tick();
        chk("exc_count", 64'(bus.count), 0);

        // Flush with a simultaneous write.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h31 + 32'(i), 6'(11 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("pre_flush_count", 64'(bus.count), 3);
        drive(1'b1, 32'h55, 6'h15, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("flush_count",     64'(bus.count), 0);
        chk("flush_not_empty", 64'(bus.not_empty), 0);
        chk("flush_read_from", 64'(bus.read_from), 0);
        chk("flush_write_to",  64'(bus.write_to), 0);
        chk("flush_overflow",  64'(bus.overflow), 1);
        drive(1'b1, 32'h66, 6'h16, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("post_flush_data", 64'(cdb_data), 64'h66);
        chk("post_flush_tag",  64'(cdb_tag), 64'h16);
        tick();
        chk("post_flush_count", 64'(bus.count), 0);

        // Flush with a simultaneous pop: head still goes out.
        drive(1'b1, 32'h71, 6'd21, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h72, 6'd22, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        chk("flush_pop_valid", 64'(bus.cdb_valid), 1);
        chk("flush_pop_data",  64'(cdb_data), 64'h71);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        chk("flush_pop_count", 64'(bus.count), 0);

        // Reset clears the sticky overflow.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("reset_overflow", 64'(bus.overflow), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
